// File: rtl/lab6_week2.sv
// lab6_week2: single-cycle RV32I-subset core with instruction ROM, data RAM and
// register file. Fetch, decode, execute and memory read are combinational from
// pc; pc, register-file and RAM updates commit together on the rising clock edge.
// The port named "return" in the design notes is called return_addr here,
// because "return" is a reserved word in SystemVerilog.
module lab6_week2 (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] instruction,
    output logic [7:0]  pc,
    output logic        halt,
    output logic [6:0]  op_code,
    output logic [1:0]  branch,
    output logic        memread,
    output logic [1:0]  memreg,
    output logic [1:0]  aluop1,
    output logic [1:0]  aluop0,
    output logic        memwrite,
    output logic [1:0]  alusrc,
    output logic        regwrite,
    output logic [1:0]  jalsignal,
    output logic [1:0]  jalrsignal,
    output logic [2:0]  zero_flag,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic [31:0] result,
    output logic [3:0]  operation_code,
    output logic [31:0] return_addr
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_HALT   = 7'b1110011;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // The program image (program.mem) is placed into rom_q by the memory
    // initialisation flow; an empty image is all-zero words, which halt.
    logic [31:0] rom_q [0:255] = '{default: 32'h0000_0000};
    logic [31:0] ram_q [0:255];
    logic [31:0] rf_q  [0:31];
    logic [31:0] rf_we;

    logic [7:0]  pc_q, pc_d, pc_plus1;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        use_imm_s;
    logic        br_taken;
    logic [31:0] imm_i, imm_s, imm_sel, operand2;
    logic [7:0]  br_off, jal_off;
    logic [31:0] mem_rdata, wb_data;

    assign pc          = pc_q;
    assign instruction = rom_q[pc_q];
    assign op_code     = instruction[6:0];
    assign rd          = instruction[11:7];
    assign funct3      = instruction[14:12];
    assign rs1         = instruction[19:15];
    assign rs2         = instruction[24:20];
    assign funct7_5    = instruction[30];

    // Sign-extended immediates; branch/jump offsets only need byte bits [9:2]
    // because the pc is a word address that wraps modulo 256.
    assign imm_i   = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s   = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign br_off  = {instruction[29:25], instruction[11:9]};
    assign jal_off = instruction[29:22];

    assign pc_plus1    = pc_q + 8'd1;
    assign return_addr = {22'd0, pc_plus1, 2'b00};

    // x0 reads as zero regardless of the storage contents.
    assign RD1 = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    assign RD2 = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

    assign zero_flag = {($signed(RD1) < $signed(RD2)), (RD1 < RD2), (RD1 == RD2)};

    // Main decoder: control signals per opcode; halt and unknown opcodes leave all enables low.
    always_comb begin
        halt       = 1'b0;
        branch     = 2'b00;
        memread    = 1'b0;
        memreg     = 2'b00;
        aluop1     = 2'b00;
        aluop0     = 2'b00;
        memwrite   = 1'b0;
        alusrc     = 2'b00;
        regwrite   = 1'b0;
        jalsignal  = 2'b00;
        jalrsignal = 2'b00;
        use_imm_s  = 1'b0;
        if (op_code == OP_HALT || instruction == 32'd0) begin
            halt = 1'b1;
        end else begin
            case (op_code)
                OP_R: begin
                    regwrite = 1'b1;
                    aluop1   = 2'b01;
                end
                OP_I: begin
                    regwrite = 1'b1;
                    aluop1   = 2'b01;
                    aluop0   = 2'b01;
                    alusrc   = 2'b01;
                end
                OP_LOAD: begin
                    if (funct3 == 3'b010) begin
                        memread  = 1'b1;
                        regwrite = 1'b1;
                        memreg   = 2'b01;
                        alusrc   = 2'b01;
                    end
                end
                OP_STORE: begin
                    if (funct3 == 3'b010) begin
                        memwrite  = 1'b1;
                        alusrc    = 2'b01;
                        use_imm_s = 1'b1;
                    end
                end
                OP_BRANCH: begin
                    branch = 2'b01;
                    aluop0 = 2'b01;
                end
                OP_JAL: begin
                    regwrite  = 1'b1;
                    jalsignal = 2'b01;
                    memreg    = 2'b10;
                end
                OP_JALR: begin
                    regwrite   = 1'b1;
                    jalrsignal = 2'b01;
                    memreg     = 2'b10;
                    alusrc     = 2'b01;
                end
                default: ;
            endcase
        end
    end

    // ALU control: ALUOp plus funct3/funct7 select the operation.
    always_comb begin
        operation_code = ALU_ADD;
        case ({aluop1[0], aluop0[0]})
            2'b00: operation_code = ALU_ADD;
            2'b01: operation_code = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000: operation_code = (!aluop0[0] && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001: operation_code = ALU_SLL;
                    3'b010: operation_code = ALU_SLT;
                    3'b011: operation_code = ALU_SLTU;
                    3'b100: operation_code = ALU_XOR;
                    3'b101: operation_code = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110: operation_code = ALU_OR;
                    default: operation_code = ALU_AND;
                endcase
            end
        endcase
    end

    assign imm_sel  = use_imm_s ? imm_s : imm_i;
    assign operand2 = alusrc[0] ? imm_sel : RD2;

    // ALU datapath.
    always_comb begin
        result = 32'd0;
        case (operation_code)
            ALU_AND:  result = RD1 & operand2;
            ALU_OR:   result = RD1 | operand2;
            ALU_ADD:  result = RD1 + operand2;
            ALU_XOR:  result = RD1 ^ operand2;
            ALU_SLL:  result = RD1 << operand2[4:0];
            ALU_SRL:  result = RD1 >> operand2[4:0];
            ALU_SUB:  result = RD1 - operand2;
            ALU_SRA:  result = $signed(RD1) >>> operand2[4:0];
            ALU_SLT:  result = {31'd0, $signed(RD1) < $signed(operand2)};
            ALU_SLTU: result = {31'd0, RD1 < operand2};
            default:  result = 32'd0;
        endcase
    end

    // Branch resolution from the comparison flags.
    always_comb begin
        br_taken = 1'b0;
        if (branch[0]) begin
            case (funct3)
                3'b000:  br_taken = zero_flag[0];
                3'b001:  br_taken = !zero_flag[0];
                3'b100:  br_taken = zero_flag[2];
                3'b101:  br_taken = !zero_flag[2];
                default: br_taken = 1'b0;
            endcase
        end
    end

    assign mem_rdata = ram_q[result[9:2]];

    // Writeback select: ALU, memory or link address.
    always_comb begin
        wb_data = result;
        case (memreg)
            2'b01:   wb_data = mem_rdata;
            2'b10:   wb_data = return_addr;
            default: wb_data = result;
        endcase
    end

    // Next-pc selection; a halt holds the pc until reset.
    always_comb begin
        pc_d = pc_plus1;
        if (halt)
            pc_d = pc_q;
        else if (jalrsignal[0])
            pc_d = result[9:2];
        else if (jalsignal[0])
            pc_d = pc_q + jal_off;
        else if (br_taken)
            pc_d = pc_q + br_off;
    end

    // Program counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pc_q <= 8'd0;
        else
            pc_q <= pc_d;
    end

    // Register file: one register per entry, x0 never written.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_rf
            assign rf_we[gi] = regwrite && (rd == 5'(gi)) && (rd != 5'd0);

            // Cleared on reset, loaded with the writeback value when selected.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    rf_q[gi] <= 32'd0;
                else if (rf_we[gi])
                    rf_q[gi] <= wb_data;
            end
        end
    endgenerate

    // Data RAM word write; contents survive reset, and a held reset blocks the write.
    always_ff @(posedge clk) begin
        if (memwrite && reset_n)
            ram_q[result[9:2]] <= RD2;
    end

endmodule

// File: tb/tb_lab6_week2.sv
// Directed bench for lab6_week2: loads two small programs into the ROM and
// checks debug outputs, next-pc and architectural state through a scoreboard.
module tb_lab6_week2;

    logic        clk;
    logic        reset_n;
    logic [31:0] instruction;
    logic [7:0]  pc;
    logic        halt;
    logic [6:0]  op_code;
    logic [1:0]  branch;
    logic        memread;
    logic [1:0]  memreg;
    logic [1:0]  aluop1;
    logic [1:0]  aluop0;
    logic        memwrite;
    logic [1:0]  alusrc;
    logic        regwrite;
    logic [1:0]  jalsignal;
    logic [1:0]  jalrsignal;
    logic [2:0]  zero_flag;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] result;
    logic [3:0]  operation_code;
    logic [31:0] return_addr;

    lab6_week2 dut (
        .clk(clk), .reset_n(reset_n), .instruction(instruction), .pc(pc),
        .halt(halt), .op_code(op_code), .branch(branch), .memread(memread),
        .memreg(memreg), .aluop1(aluop1), .aluop0(aluop0), .memwrite(memwrite),
        .alusrc(alusrc), .regwrite(regwrite), .jalsignal(jalsignal),
        .jalrsignal(jalrsignal), .zero_flag(zero_flag), .RD1(RD1), .RD2(RD2),
        .result(result), .operation_code(operation_code), .return_addr(return_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_PC = 0, S_INSTR = 1, S_HALT = 2, S_RESULT = 3, S_RD1 = 4,
                   S_RD2 = 5, S_OPC = 6, S_ZF = 7, S_RET = 8, S_REGW = 9,
                   S_MEMW = 10, S_MEMR = 11, S_MEMREG = 12, S_BRANCH = 13,
                   S_JAL = 14, S_JALR = 15, S_ALUOP = 16, S_ALUSRC = 17,
                   S_OPCODE = 18, S_REG = 19;

    typedef struct {
        string       tag;
        int          sig;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] obs(input int sig, input int idx);
        case (sig)
            S_PC:     return {24'd0, pc};
            S_INSTR:  return instruction;
            S_HALT:   return {31'd0, halt};
            S_RESULT: return result;
            S_RD1:    return RD1;
            S_RD2:    return RD2;
            S_OPC:    return {28'd0, operation_code};
            S_ZF:     return {29'd0, zero_flag};
            S_RET:    return return_addr;
            S_REGW:   return {31'd0, regwrite};
            S_MEMW:   return {31'd0, memwrite};
            S_MEMR:   return {31'd0, memread};
            S_MEMREG: return {30'd0, memreg};
            S_BRANCH: return {30'd0, branch};
            S_JAL:    return {30'd0, jalsignal};
            S_JALR:   return {30'd0, jalrsignal};
            S_ALUOP:  return {28'd0, aluop1, aluop0};
            S_ALUSRC: return {30'd0, alusrc};
            S_OPCODE: return {25'd0, op_code};
            S_REG:    return dut.rf_q[idx];
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_v(input string tag, input int sig, input logic [31:0] v, input int idx = 0);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.idx = idx;
        e.exp = v;
        sb.push_back(e);
    endtask

    // Pop every pending expectation and compare against the DUT now.
    task automatic drain();
        exp_t        e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sig, e.idx);
            total++;
            assert (o === e.exp) else begin
                bad++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, o, e.exp);
            end
            $display("check %-14s observed=%h expected=%h", e.tag, o, e.exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) dut.rom_q[i] = 32'd0;
    endtask

    task automatic rom_w(input int a, input logic [31:0] w);
        dut.rom_q[a] = w;
    endtask

    initial begin
        reset_n = 1'b0;
        #1;
        // Program A: arithmetic, BEQ/BNE, JAL/JALR, halt at 10
        rom_clear();
        rom_w(0,  32'h0050_0093); // ADDI x1,x0,5
        rom_w(1,  32'hFFD0_0113); // ADDI x2,x0,-3
        rom_w(2,  32'h0020_81B3); // ADD  x3,x1,x2
        rom_w(3,  32'h0010_8463); // BEQ  x1,x1,+8
        rom_w(4,  32'h0630_0193); // ADDI x3,x0,99 (skipped)
        rom_w(5,  32'h0010_9463); // BNE  x1,x1,+8
        rom_w(6,  32'h00C0_00EF); // JAL  x1,+12
        rom_w(7,  32'h0280_0093); // ADDI x1,x0,40
        rom_w(8,  32'h0010_0613); // ADDI x12,x0,1
        rom_w(9,  32'h0000_8067); // JALR x0,0(x1)
        rom_w(10, 32'h0000_0073); // halt

        @(negedge clk);
        expect_v("rst_pc", S_PC, 32'd0);
        expect_v("rst_instr", S_INSTR, 32'h0050_0093);
        expect_v("rst_halt", S_HALT, 32'd0);
        expect_v("rst_x1", S_REG, 32'd0, 1);
        drain();
        reset_n = 1'b1;

        expect_v("addi_res", S_RESULT, 32'd5);
        expect_v("addi_aluop", S_ALUOP, 32'b0101);
        expect_v("addi_alusrc", S_ALUSRC, 32'b01);
        expect_v("addi_opcode", S_OPCODE, 32'h13);
        drain();
        cyc();
        expect_v("pc1", S_PC, 32'd1);
        expect_v("x1_5", S_REG, 32'd5, 1);
        expect_v("addi_neg_res", S_RESULT, 32'hFFFF_FFFD);
        drain();
        cyc();
        expect_v("add_rd1", S_RD1, 32'd5);
        expect_v("add_rd2", S_RD2, 32'hFFFF_FFFD);
        expect_v("add_res", S_RESULT, 32'd2);
        expect_v("add_opc", S_OPC, 32'b0010);
        expect_v("add_zf", S_ZF, 32'b010);
        expect_v("add_aluop", S_ALUOP, 32'b0100);
        drain();
        cyc();
        expect_v("beq_pc", S_PC, 32'd3);
        expect_v("x3_2", S_REG, 32'd2, 3);
        expect_v("beq_zf", S_ZF, 32'b001);
        expect_v("beq_branch", S_BRANCH, 32'b01);
        expect_v("beq_opc", S_OPC, 32'b0110);
        expect_v("beq_aluop", S_ALUOP, 32'b0001);
        drain();
        cyc();
        expect_v("beq_next_pc", S_PC, 32'd5);
        drain();
        cyc();
        expect_v("bne_next_pc", S_PC, 32'd6);
        expect_v("jal_ret", S_RET, 32'd28);
        expect_v("jal_sig", S_JAL, 32'b01);
        expect_v("jal_memreg", S_MEMREG, 32'b10);
        drain();
        cyc();
        expect_v("jal_next_pc", S_PC, 32'd9);
        expect_v("jal_x1", S_REG, 32'd28, 1);
        expect_v("jalr_rd1", S_RD1, 32'd28);
        expect_v("jalr_sig", S_JALR, 32'b01);
        drain();
        cyc();
        expect_v("jalr_next_pc", S_PC, 32'd7);
        drain();
        cyc();
        cyc();
        expect_v("jalr2_rd1", S_RD1, 32'd40);
        drain();
        cyc();
        expect_v("halt_pc", S_PC, 32'd10);
        expect_v("halt_flag", S_HALT, 32'd1);
        expect_v("halt_regw", S_REGW, 32'd0);
        expect_v("halt_memw", S_MEMW, 32'd0);
        drain();
        for (int k = 0; k < 5; k++) begin
            cyc();
            expect_v("halt_hold_pc", S_PC, 32'd10);
            expect_v("halt_hold", S_HALT, 32'd1);
            drain();
        end
        expect_v("x3_kept", S_REG, 32'd2, 3);
        expect_v("x12_1", S_REG, 32'd1, 12);
        expect_v("x1_40", S_REG, 32'd40, 1);
        drain();

        // Mid-cycle asynchronous reset
        #2;
        reset_n = 1'b0;
        #1;
        expect_v("async_pc", S_PC, 32'd0);
        expect_v("async_halt", S_HALT, 32'd0);
        expect_v("async_x1", S_REG, 32'd0, 1);
        drain();

        // Program B: SUB/SLT/SLTU, BNE, SW/LW, SRAI, x0 write, illegal, zero halt
        rom_clear();
        rom_w(0,  32'h0050_0093); // ADDI x1,x0,5
        rom_w(1,  32'hFFD0_0113); // ADDI x2,x0,-3
        rom_w(2,  32'h4020_82B3); // SUB  x5,x1,x2
        rom_w(3,  32'h0010_9463); // BNE  x1,x1,+8
        rom_w(4,  32'h0020_A333); // SLT  x6,x1,x2
        rom_w(5,  32'h0020_B3B3); // SLTU x7,x1,x2
        rom_w(6,  32'h0010_2423); // SW   x1,8(x0)
        rom_w(7,  32'h0080_2203); // LW   x4,8(x0)
        rom_w(8,  32'h0042_0433); // ADD  x8,x4,x4
        rom_w(9,  32'h4011_5493); // SRAI x9,x2,1
        rom_w(10, 32'h0070_8013); // ADDI x0,x1,7
        rom_w(11, 32'h0010_0533); // ADD  x10,x0,x1
        rom_w(12, 32'h0000_007F); // illegal opcode
        rom_w(13, 32'h0000_0000); // all-zero halt

        @(negedge clk);
        reset_n = 1'b1;
        cyc();
        cyc();
        expect_v("sub_res", S_RESULT, 32'd8);
        expect_v("sub_opc", S_OPC, 32'b0110);
        drain();
        cyc();
        expect_v("bne_pc", S_PC, 32'd3);
        drain();
        cyc();
        expect_v("bne_eq_next", S_PC, 32'd4);
        expect_v("slt_res", S_RESULT, 32'd0);
        expect_v("slt_opc", S_OPC, 32'b1000);
        drain();
        cyc();
        expect_v("sltu_res", S_RESULT, 32'd1);
        expect_v("sltu_opc", S_OPC, 32'b1001);
        expect_v("sltu_zf", S_ZF, 32'b010);
        drain();
        cyc();
        expect_v("sw_memw", S_MEMW, 32'd1);
        expect_v("sw_regw", S_REGW, 32'd0);
        expect_v("sw_res", S_RESULT, 32'd8);
        expect_v("sw_rd2", S_RD2, 32'd5);
        drain();
        cyc();
        expect_v("lw_memr", S_MEMR, 32'd1);
        expect_v("lw_memreg", S_MEMREG, 32'b01);
        expect_v("lw_regw", S_REGW, 32'd1);
        drain();
        cyc();
        expect_v("lw_x4", S_REG, 32'd5, 4);
        expect_v("ldu_rd1", S_RD1, 32'd5);
        expect_v("ldu_res", S_RESULT, 32'd10);
        drain();
        cyc();
        expect_v("srai_res", S_RESULT, 32'hFFFF_FFFE);
        expect_v("srai_opc", S_OPC, 32'b0111);
        drain();
        cyc();
        expect_v("x0w_res", S_RESULT, 32'd12);
        drain();
        cyc();
        expect_v("x0_rd1", S_RD1, 32'd0);
        expect_v("x0_res", S_RESULT, 32'd5);
        expect_v("x0_reg", S_REG, 32'd0, 0);
        drain();
        cyc();
        expect_v("ill_pc", S_PC, 32'd12);
        expect_v("ill_regw", S_REGW, 32'd0);
        expect_v("ill_memw", S_MEMW, 32'd0);
        expect_v("ill_halt", S_HALT, 32'd0);
        drain();
        cyc();
        expect_v("zhalt_pc", S_PC, 32'd13);
        expect_v("zhalt_flag", S_HALT, 32'd1);
        expect_v("x10_5", S_REG, 32'd5, 10);
        expect_v("x9_m2", S_REG, 32'hFFFF_FFFE, 9);
        drain();
        cyc();
        expect_v("zhalt_hold", S_PC, 32'd13);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
